// File: rtl/pll_lock_supervisor_if.sv
// PLL supervisor signal bundle: lock/restart inputs plus PLL control and status outputs.
interface pll_lock_supervisor_if;
  logic       lock_raw;
  logic       restart;
  logic       pll_reset;
  logic       pll_ready;
  logic       fault;
  logic       lock_lost;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  // The supervisor side drives PLL control and status.
  modport master (
    input  lock_raw,
    input  restart,
    output pll_reset,
    output pll_ready,
    output fault,
    output lock_lost,
    output retry_cnt,
    output state
  );

  // The PLL/board side supplies lock and restart and observes status.
  modport slave (
    output lock_raw,
    output restart,
    input  pll_reset,
    input  pll_ready,
    input  fault,
    input  lock_lost,
    input  retry_cnt,
    input  state
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences the rPLL from the reference clock domain: holds RESET, waits for
// a synchronized lock, qualifies it over a stability window, retries on
// timeout and parks in FAULT once the retry budget is spent.
module pll_lock_supervisor #(
  parameter int RESET_CYCLES        = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 270000,
  parameter int MAX_RETRIES         = 3
) (
  input logic clk,
  input logic rst_n,
  pll_lock_supervisor_if.master bus
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    READY     = 3'd3,
    FAULT     = 3'd4
  } state_t;

  // The phase counter serves both the reset hold and the stability window.
  localparam int PHASE_MAX = (RESET_CYCLES > LOCK_STABLE_CYCLES) ? RESET_CYCLES : LOCK_STABLE_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX) + 1;
  localparam int TMO_W     = $clog2(LOCK_TIMEOUT_CYCLES) + 1;

  localparam logic [PHASE_W-1:0] RESET_LAST  = PHASE_W'(RESET_CYCLES - 1);
  localparam logic [PHASE_W-1:0] STABLE_LAST = PHASE_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]         RETRY_MAX   = 4'(MAX_RETRIES);

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [3:0]         retry_q, retry_d;
  logic               lock_lost_q, lock_lost_d;
  logic               lock_meta_q, lock_s_q;
  logic               lock_timeout;
  logic               retry_avail;

  // Two-flop synchronizer bringing the asynchronous PLL LOCK into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= bus.lock_raw;
      lock_s_q    <= lock_meta_q;
    end
  end

  // A greater-or-equal compare keeps the timeout firing even if a lock
  // drop in STABLE hands WAIT_LOCK a count already at the limit.
  assign lock_timeout = (tmo_q >= TMO_LAST);
  assign retry_avail  = (retry_q < RETRY_MAX);

  // Next-state logic: sequencing, counters, retry budget and restart override.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    tmo_d       = tmo_q;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;

    if (state_q == RESET_PLL || state_q == STABLE) begin
      phase_d = phase_q + PHASE_W'(1);
    end
    if (state_q == WAIT_LOCK || state_q == STABLE) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      RESET_PLL: begin
        if (phase_q == RESET_LAST) begin
          state_d = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = STABLE;
        end else if (lock_timeout) begin
          if (retry_avail) begin
            retry_d = retry_q + 4'd1;
            state_d = RESET_PLL;
          end else begin
            state_d = FAULT;
          end
        end
      end
      STABLE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (lock_timeout) begin
          if (retry_avail) begin
            retry_d = retry_q + 4'd1;
            state_d = RESET_PLL;
          end else begin
            state_d = FAULT;
          end
        end else if (phase_q == STABLE_LAST) begin
          state_d = READY;
        end
      end
      READY: begin
        if (!lock_s_q) begin
          lock_lost_d = 1'b1;
          retry_d     = 4'd0;
          state_d     = RESET_PLL;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = RESET_PLL;
      end
    endcase

    // Every state starts its phase count from zero; the timeout window
    // only restarts when the PLL is reset again.
    if (state_d != state_q) begin
      phase_d = '0;
    end
    if (state_d == RESET_PLL && state_q != RESET_PLL) begin
      tmo_d = '0;
    end

    // Restart beats every other transition, including a coincident timeout.
    if (bus.restart) begin
      state_d     = RESET_PLL;
      phase_d     = '0;
      tmo_d       = '0;
      retry_d     = 4'd0;
      lock_lost_d = 1'b0;
    end
  end

  // State, counter and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_PLL;
      phase_q     <= '0;
      tmo_q       <= '0;
      retry_q     <= 4'd0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  // Outputs decode only registered state, so no input reaches them combinationally.
  assign bus.pll_reset = (state_q == RESET_PLL) || (state_q == FAULT);
  assign bus.pll_ready = (state_q == READY);
  assign bus.fault     = (state_q == FAULT);
  assign bus.lock_lost = lock_lost_q;
  assign bus.retry_cnt = retry_q;
  assign bus.state     = state_q;

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequences the board's single rPLL instance (27 MHz crystal in, 24 MHz audio/system clock out) from the 27 MHz reference domain. Drives the PLL RESET input, synchronizes the asynchronous LOCK output, and qualifies lock with a stability window. It retries on lock timeout and declares a fault after a bounded number of retries. Its `pll_ready` output gates release of the PDM audio datapath's reset.

## Interface
- RESET_CYCLES, 16: cycles `pll_reset` is held high per reset attempt (≥1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before ready (≥1).
- LOCK_TIMEOUT_CYCLES, 270000: cycles allowed from PLL reset release to qualified lock (10 ms at 27 MHz).
- MAX_RETRIES, 3: reset re-attempts after the first before entering FAULT (0..15).

Ports:
- clk  in  1  27 MHz reference clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lock_raw  in  1  PLL LOCK output, asynchronous to `clk`.
- restart  in  1  synchronous single-cycle request to restart sequencing.
- pll_reset  out  1  to the PLL RESET input; active high.
- pll_ready  out  1  high only in READY.
- fault  out  1  high only in FAULT.
- lock_lost  out  1  sticky; set when lock drops while in READY.
- retry_cnt  out  4  retries consumed since the last rst_n or restart.
- state  out  3  debug encoding: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, READY=3, FAULT=4.

## Operation
- Lock synchronizer: two flops, both reset to 0. `lock_s` is the second flop. All decisions use `lock_s` only.
- Counters:
  - `phase_cnt` is used for the reset-hold and stability counts and is zeroed on every state entry.
  - `tmo_cnt` runs in WAIT_LOCK and STABLE. It is zeroed on entry to RESET_PLL.
  - Size both counters with $clog2 of the largest parameter they compare against, +1.
- RESET_PLL: `pll_reset`=1. When `phase_cnt` reaches RESET_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK: `pll_reset`=0.
  - If `lock_s`=1, go to STABLE.
  - Else, if `tmo_cnt` reaches LOCK_TIMEOUT_CYCLES-1: if `retry_cnt`<MAX_RETRIES, increment `retry_cnt` and go to RESET_PLL; otherwise go to FAULT.
- STABLE:
  - If `lock_s`=0, go back to WAIT_LOCK. `tmo_cnt` is not cleared on this transition.
  - Else, when `phase_cnt` reaches LOCK_STABLE_CYCLES-1, go to READY.
  - Timeout is checked in STABLE exactly as in WAIT_LOCK. Timeout has priority over reaching READY on the same cycle.
- READY: `pll_ready`=1.
  - If `lock_s`=0: set `lock_lost`, clear `retry_cnt` to 0, and go to RESET_PLL.
- FAULT: `fault`=1 and `pll_reset`=1 (PLL held in reset). Only `restart` or `rst_n` exits this state.
- restart: in every state, a pulse forces RESET_PLL and zeroes both counters and `retry_cnt`. `lock_lost` is cleared. `restart` has priority over all other transitions on the same edge.
- `retry_cnt` saturates at MAX_RETRIES and never wraps.

## Timing
- During rst_n low, and at its release: state=RESET_PLL, `pll_reset`=1, `pll_ready`=0, `fault`=0, `lock_lost`=0, `retry_cnt`=0, `state`=0.
- `pll_reset` stays high for exactly RESET_CYCLES rising edges after rst_n deasserts (or after the edge that samples `restart`).
- lock_raw to `lock_s` latency: 2 edges.
- `pll_ready` rises 2+1+LOCK_STABLE_CYCLES edges after the edge that first samples `lock_raw` high in WAIT_LOCK, provided lock holds throughout.
- `pll_ready` falls 3 edges after `lock_raw` falls. `pll_reset` rises on that same edge.
- All outputs are registered. No combinational path exists from any input to any output.
- Asserting rst_n mid-operation returns every output to its reset value immediately (asynchronously).

## Test plan
Use RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, MAX_RETRIES=2.
1. Normal bring-up: release rst_n, raise `lock_raw` 10 cycles later and hold it → `pll_reset` is high for edges 1–4; `pll_ready` rises 11 edges after `lock_raw` is first sampled; `retry_cnt`=0.
2. Glitchy lock: in STABLE, drop `lock_raw` for 1 cycle at stability count 5, then hold it high → state returns to WAIT_LOCK and re-qualifies the full 8 cycles; `pll_ready` is delayed accordingly; no retry is consumed.
3. Timeout and fault: hold `lock_raw`=0 → three `pll_reset` pulses of 4 cycles each; `retry_cnt` steps 0→1→2; after the third 64-cycle timeout, `fault`=1 and `pll_reset` stays high.
4. Restart from FAULT: pulse `restart` → next edge shows state=0 and `retry_cnt`=0; with `lock_raw`=1, `pll_ready` is reached again.
5. Lock loss in READY: drop `lock_raw` → 3 edges later `pll_ready`=0, `pll_reset`=1, `lock_lost`=1; relock then reaches READY with `lock_lost` still 1.
6. Async reset while in STABLE, and `restart` on the same edge as a timeout → all outputs return to reset values immediately; the restart wins and no `retry_cnt` increment occurs.
